// File: rtl/elastic_buffer_pkg.sv
// Shared defaults for the front-end elastic buffer.
package elastic_buffer_pkg;
  localparam int EB_DEFAULT_W     = 32;
  localparam int EB_DEFAULT_DEPTH = 4;
endpackage

// File: rtl/elastic_buffer.sv
// Valid/ready elastic FIFO between front-end stages with optional zero-latency
// bypass, registered-ready mode, occupancy and almost-full status.
module elastic_buffer
  import elastic_buffer_pkg::*;
#(
  parameter type T          = logic [EB_DEFAULT_W-1:0],
  parameter int  DEPTH      = EB_DEFAULT_DEPTH,
  parameter bit  BYPASS     = 1'b1,
  parameter bit  PIPE_READY = 1'b0,
  parameter int  AF_THRESH  = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       mispredict,
  input  logic                       valid_in,
  input  T                           data_in,
  output logic                       ready_in,
  input  logic                       ready_out,
  output logic                       valid_out,
  output T                           data_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam int CW = $clog2(DEPTH + 1);

  T              mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          bypass_fire;
  logic          store;
  logic          unload;
  logic [CW-1:0] count_nxt;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (head == tail);
  assign full  = (head[IW-1:0] == tail[IW-1:0]) && (head[IW] != tail[IW]);

  always_comb begin
    valid_out = 1'b0;
    data_out  = '0;
    ready_in  = 1'b0;
    if (reset_n && mispredict) begin
      ready_in = 1'b1;
    end else if (reset_n) begin
      ready_in = PIPE_READY ? !full : (!full || ready_out);
      if (!empty) begin
        valid_out = 1'b1;
        data_out  = mem[head[IW-1:0]];
      end else if (BYPASS && valid_in) begin
        valid_out = 1'b1;
        data_out  = data_in;
      end
    end
  end

  assign push        = valid_in && ready_in && !mispredict;
  assign pop         = valid_out && ready_out;
  assign bypass_fire = BYPASS && empty && push && pop;
  assign store       = push && !bypass_fire;
  assign unload      = pop && !empty;
  assign count_nxt   = count + CW'(store) - CW'(unload);

  // When full with PIPE_READY=0, the write lands in the slot the pop frees.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      almost_full <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mispredict) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      almost_full <= (AF_THRESH <= 0);
    end else begin
      if (store) begin
        mem[tail[IW-1:0]] <= data_in;
        tail              <= tail + PW'(1);
      end
      if (unload) begin
        head <= head + PW'(1);
      end
      count       <= count_nxt;
      almost_full <= (int'(count_nxt) >= AF_THRESH);
    end
  end

endmodule

// File: tb/tb_elastic_buffer.sv
// Directed bench for elastic_buffer: one PIPE_READY=0 and one PIPE_READY=1
// instance share the same stimulus.
module tb_elastic_buffer;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        mispredict;
  logic        valid_in;
  logic [31:0] data_in;
  logic        ready_out;

  logic        ready_in0, valid_out0, af0;
  logic [31:0] data_out0;
  logic [2:0]  count0;
  logic        ready_in1, valid_out1, af1;
  logic [31:0] data_out1;
  logic [2:0]  count1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  elastic_buffer #(.DEPTH(4), .BYPASS(1'b1), .PIPE_READY(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .mispredict(mispredict),
    .valid_in(valid_in), .data_in(data_in), .ready_in(ready_in0),
    .ready_out(ready_out), .valid_out(valid_out0), .data_out(data_out0),
    .count(count0), .almost_full(af0)
  );

  elastic_buffer #(.DEPTH(4), .BYPASS(1'b1), .PIPE_READY(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .mispredict(mispredict),
    .valid_in(valid_in), .data_in(data_in), .ready_in(ready_in1),
    .ready_out(ready_out), .valid_out(valid_out1), .data_out(data_out1),
    .count(count1), .almost_full(af1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    int rx;
    reset_n    = 1'b0;
    mispredict = 1'b0;
    valid_in   = 1'b0;
    data_in    = '0;
    ready_out  = 1'b0;
    repeat (2) tick();

    chk("rst_valid_out", 32'(valid_out0), 32'd0);
    chk("rst_ready_in",  32'(ready_in0),  32'd0);
    chk("rst_count",     32'(count0),     32'd0);
    chk("rst_af",        32'(af0),        32'd0);
    chk("rst_data_out",  data_out0,       32'd0);

    reset_n = 1'b1;
    #1;
    chk("post_rst_ready_in", 32'(ready_in0), 32'd1);

    // zero-latency bypass
    valid_in = 1'b1; data_in = 32'h11; ready_out = 1'b1;
    #1;
    chk("byp_valid_out", 32'(valid_out0), 32'd1);
    chk("byp_data_out",  data_out0,       32'h11);
    tick();
    valid_in = 1'b0;
    #1;
    chk("byp_count",     32'(count0),     32'd0);
    chk("byp_idle_vout", 32'(valid_out0), 32'd0);

    // fill with downstream stalled
    ready_out = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid_in = 1'b1; data_in = 32'hA0 + 32'(i);
      #1;
      chk("fill_ready_in", 32'(ready_in0), 32'd1);
      tick();
      chk("fill_count", 32'(count0), 32'(i + 1));
      chk("fill_af",    32'(af0),    32'(i + 1 >= 3));
    end
    data_in = 32'hA4;
    #1;
    chk("full_ready_in", 32'(ready_in0),  32'd0);
    chk("full_vout",     32'(valid_out0), 32'd1);
    chk("full_head",     data_out0,       32'hA0);
    valid_in = 1'b0;

    // drain in order
    ready_out = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_data",  data_out0,       32'hA0 + 32'(i));
      chk("drain_valid", 32'(valid_out0), 32'd1);
      tick();
      chk("drain_count", 32'(count0), 32'(3 - i));
    end
    ready_out = 1'b0;

    // refill, then push+pop while full
    for (int i = 0; i < 4; i++) begin
      valid_in = 1'b1; data_in = 32'hA0 + 32'(i);
      tick();
    end
    chk("refill_count0", 32'(count0), 32'd4);
    chk("refill_count1", 32'(count1), 32'd4);
    valid_in = 1'b1; data_in = 32'hB0; ready_out = 1'b1;
    #1;
    chk("fullpp_rdy0",  32'(ready_in0), 32'd1);
    chk("fullpp_rdy1",  32'(ready_in1), 32'd0);
    chk("fullpp_data0", data_out0,      32'hA0);
    chk("fullpp_data1", data_out1,      32'hA0);
    tick();
    valid_in = 1'b0;
    chk("fullpp_count0", 32'(count0), 32'd4);
    chk("fullpp_count1", 32'(count1), 32'd3);
    #1;
    chk("pop_a1_data0", data_out0, 32'hA1);
    tick();
    chk("pop_a1_count0", 32'(count0), 32'd3);
    chk("pop_a1_count1", 32'(count1), 32'd2);
    ready_out = 1'b0;

    // mispredict flush with a live input beat
    mispredict = 1'b1; valid_in = 1'b1; data_in = 32'hCC;
    #1;
    chk("mp_valid_out", 32'(valid_out0), 32'd0);
    chk("mp_data_out",  data_out0,       32'd0);
    chk("mp_ready_in",  32'(ready_in0),  32'd1);
    tick();
    mispredict = 1'b0; valid_in = 1'b0;
    #1;
    chk("mp_count0", 32'(count0),     32'd0);
    chk("mp_count1", 32'(count1),     32'd0);
    chk("mp_af0",    32'(af0),        32'd0);
    chk("mp_vout",   32'(valid_out0), 32'd0);
    ready_out = 1'b1;
    repeat (2) begin
      tick();
      chk("mp_no_cc", 32'(valid_out0), 32'd0);
    end

    // wrap-around with ready_out toggling 1010...
    idx = 0;
    rx  = 0;
    for (int cyc = 0; cyc < 40 && rx < 10; cyc++) begin
      ready_out = (cyc % 2 == 0);
      valid_in  = (idx < 10);
      data_in   = 32'(idx);
      #1;
      if (valid_out0 && ready_out) begin
        chk("wrap_order", data_out0, 32'(rx));
        rx++;
      end
      if (valid_in && ready_in0) idx++;
      tick();
    end
    valid_in = 1'b0;
    chk("wrap_received", 32'(rx), 32'd10);
    #1;
    chk("wrap_count", 32'(count0), 32'd0);

    // async reset mid-transfer
    ready_out = 1'b0;
    valid_in = 1'b1; data_in = 32'h60; tick();
    data_in = 32'h61; tick();
    valid_in = 1'b0;
    chk("pre_rst_count", 32'(count0), 32'd2);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid_out", 32'(valid_out0), 32'd0);
    chk("arst_ready_in",  32'(ready_in0),  32'd0);
    chk("arst_count",     32'(count0),     32'd0);
    chk("arst_data_out",  data_out0,       32'd0);
    tick();
    reset_n = 1'b1;
    valid_in = 1'b1; data_in = 32'h55;
    #1;
    chk("rel_ready_in", 32'(ready_in0), 32'd1);
    tick();
    valid_in = 1'b0;
    #1;
    chk("rel_valid_out", 32'(valid_out0), 32'd1);
    chk("rel_first",     data_out0,       32'h55);
    chk("rel_count",     32'(count0),     32'd1);
    ready_out = 1'b1;
    tick();
    chk("rel_drained", 32'(count0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/elastic_buffer.md
Name: elastic_buffer

Overview:
- Parametrised multi-entry successor to the 2-entry skid stage; a valid/ready elastic FIFO placed between front-end stages (fetch→decode, decode→rename, rename→dispatch).
- Adds configurable depth, optional zero-latency bypass, a registered-ready mode that breaks the ready_out→ready_in combinational path, and occupancy/almost-full status for upstream throttling.
- Flushes completely on mispredict.

Parameters:
- T, logic [31:0], payload type.
- DEPTH, 4, number of storage entries; power of two, ≥2.
- BYPASS, 1, when 1 an empty buffer forwards data_in combinationally to data_out.
- PIPE_READY, 0, when 1 ready_in depends only on registered state, not on ready_out.
- AF_THRESH, DEPTH-1, almost_full asserts when count ≥ AF_THRESH.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mispredict  in  1  synchronous flush.
- valid_in  in  1  upstream valid.
- data_in  in  T  upstream payload.
- ready_in  out  1  buffer can accept.
- ready_out  in  1  downstream ready.
- valid_out  out  1  downstream valid.
- data_out  out  T  downstream payload.
- count  out  $clog2(DEPTH+1)  stored entries (bypassed beats excluded).
- almost_full  out  1  count ≥ AF_THRESH.

Behaviour:
- Interface: one clock, clk; reset_n is asynchronous and active-low.
- Storage: circular array of DEPTH entries of T; head/tail pointers of $clog2(DEPTH)+1 bits. The extra MSB distinguishes full from empty. Pointers wrap modulo 2·DEPTH, and the index is ptr[$clog2(DEPTH)-1:0].
- empty = (head==tail); full = index equal and MSB differs.
- Handshake: push = valid_in && ready_in; pop = valid_out && ready_out. Transfers complete on the rising edge.
- Reset (reset_n=0, asynchronous):
  - head=tail=0, storage cleared to '0.
  - valid_out=0, data_out='0, ready_in=0, count=0, almost_full=0.
  - First accept is possible in the first cycle after deassertion.
- Mispredict (synchronous, while reset_n=1):
  - Combinationally forces valid_out=0, data_out='0, ready_in=1. The input beat in that cycle is discarded.
  - Next edge: head=tail=0, count=0. Mispredict overrides any push or pop in the same cycle.
- Output select:
  - Not empty: valid_out=1, data_out=mem[head].
  - Empty and BYPASS=1: valid_out=valid_in, data_out=data_in.
  - Empty and BYPASS=0: valid_out=0, data_out='0.
  - data_out is '0 whenever valid_out=0.
- Bypass rule: empty, BYPASS=1, valid_in and ready_out → beat passes with 0 latency and is not written. Empty with valid_in and !ready_out → written at tail. Latency is 0 cycles via bypass, otherwise 1 cycle minimum.
- ready_in:
  - PIPE_READY=0: !full || ready_out. Push and pop may coincide when full; the write lands in the slot freed by the pop.
  - PIPE_READY=1: !full only. The full buffer stalls one cycle even if ready_out=1.
- Pointer update: push without bypass → tail+1; pop from storage → head+1; both may occur in one cycle, leaving count unchanged.
- count and almost_full are registered; they reflect state after the last edge.
- Ordering: strict FIFO, no duplication or loss except on mispredict/reset.
- Protocol: once valid_out=1 with ready_out=0, data_out holds stable until pop or flush.

Decomposition:
- types_pkg: add no new types; payload T is supplied per instance (e.g. decode/rename packet structs already in the package).
- Pointer and count widths are localparams computed inside the module.
- No sub-module: storage and control are inline, about 150–200 lines.
- Assertion checks (no push when !ready_in, count ≤ DEPTH) are in a bind file owned by verification.

Test Plan:
- DEPTH=4, BYPASS=1, ready_out=1, send 0x11 → valid_out=1, data_out=0x11 in the same cycle; count stays 0.
- ready_out=0, push 0xA0..0xA3 → count=4, ready_in=0 (PIPE_READY=0), almost_full=1 from count=3. Then ready_out=1 for 4 cycles → pops A0,A1,A2,A3 in order; count returns to 0.
- Full buffer, PIPE_READY=0, valid_in=1 (0xB0), ready_out=1 → simultaneous pop of head and push of B0; count stays 4. Repeat with PIPE_READY=1 → ready_in=0, count drops to 3.
- Wrap-around: push/pop 10 beats 0x00..0x09 with ready_out toggling 1010… → output order 0x00..0x09, no gaps; pointers wrap past 2·DEPTH.
- count=3, assert mispredict with valid_in=1 (0xCC) → same cycle valid_out=0, ready_in=1; next cycle count=0, 0xCC never appears.
- Drive reset_n low mid-transfer with count=2 (asynchronous, between edges) → valid_out=0, ready_in=0, count=0 immediately. After release, push 0x55 → emerges as first beat.
